// File: rtl/decoder_clkgen_pkg.sv
// Shared widths and decode helper for the 3:8 decoder with clock generator.
package decoder_clkgen_pkg;

   localparam int SEL_W = 3;
   localparam int OUT_W = 8;
   localparam int CNT_W = 8;

   function automatic logic [OUT_W-1:0] one_hot(input logic [SEL_W-1:0] sel);
      logic [OUT_W-1:0] v;
      v      = '0;
      v[sel] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/clk_div_gen.sv
// Divides clk by 2*DIV_HALF; output toggles each time the down-counter
// wraps, and is taken straight from a flop so it cannot glitch.
module clk_div_gen
   import decoder_clkgen_pkg::*;
#(
   parameter int unsigned DIV_HALF = 1
) (
   input  logic clk,
   input  logic rst_n,
   output logic clk_out
);

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIV_HALF - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             clk_q;
   logic             clk_d;

   always_comb begin
      cnt_d = cnt_q - CNT_W'(1);
      clk_d = clk_q;
      if (cnt_q == '0) begin
         cnt_d = RELOAD;
         clk_d = ~clk_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= RELOAD;
         clk_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         clk_q <= clk_d;
      end
   end

   assign clk_out = clk_q;

endmodule

// File: rtl/decoder_clkgen.sv
// 3:8 enabled decoder plus forwarded and divided clocks.
// Define DECODER_OUT_REG_EN to register Out (1-cycle latency).
module decoder_clkgen
   import decoder_clkgen_pkg::*;
#(
   parameter int unsigned DIV_HALF = 1
) (
   input  logic             clka,
   input  logic             rst_n,
   input  logic             E,
   input  logic [SEL_W-1:0] In,
   output logic [OUT_W-1:0] Out,
   output logic             clka_out,
   output logic             clkb_out
);

   logic [OUT_W-1:0] out_d;

   always_comb begin
      out_d = '0;
      if (E) out_d = one_hot(In);
   end

`ifdef DECODER_OUT_REG_EN
   logic [OUT_W-1:0] out_q;

   // Whole-vector register: the one-hot word switches atomically.
   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) out_q <= '0;
      else        out_q <= out_d;
   end

   assign Out = out_q;
`else
   assign Out = out_d;
`endif

   assign clka_out = clka;

   clk_div_gen #(
      .DIV_HALF (DIV_HALF)
   ) u_clk_div_gen (
      .clk     (clka),
      .rst_n   (rst_n),
      .clk_out (clkb_out)
   );

endmodule

// File: tb/tb_decoder_clkgen.sv
// Randomized bench for decoder_clkgen (DIV_HALF = 1 and 3) against an
// edge-count model, plus literal expectations for the directed cases.
module tb_decoder_clkgen;

   logic       clka;
   logic       rst_n;
   logic       E;
   logic [2:0] In;
   logic [7:0] out_a, out_b;
   logic       clka_out_a, clka_out_b;
   logic       clkb_a, clkb_b;

   int n_chk  = 0;
   int n_fail = 0;

   decoder_clkgen #(.DIV_HALF(1)) dut_a (
      .clka     (clka),
      .rst_n    (rst_n),
      .E        (E),
      .In       (In),
      .Out      (out_a),
      .clka_out (clka_out_a),
      .clkb_out (clkb_a)
   );

   decoder_clkgen #(.DIV_HALF(3)) dut_b (
      .clka     (clka),
      .rst_n    (rst_n),
      .E        (E),
      .In       (In),
      .Out      (out_b),
      .clka_out (clka_out_b),
      .clkb_out (clkb_b)
   );

   initial clka = 1'b0;
   always #10 clka = ~clka;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] dec(input logic e, input logic [2:0] s);
      return e ? (8'd1 << s) : 8'd0;
   endfunction

   // Model: rising edges since reset release, and last captured decode.
   int         edges;
   logic [7:0] dec_prev;

   always @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         edges    <= 0;
         dec_prev <= 8'd0;
      end else begin
         edges    <= edges + 1;
         dec_prev <= dec(E, In);
      end
   end

   function automatic logic clkb_model(input int k, input int half);
      return ((k / half) % 2) == 1;
   endfunction

   function automatic logic [7:0] out_model();
`ifdef DECODER_OUT_REG_EN
      return dec_prev;
`else
      return dec(E, In);
`endif
   endfunction

   initial begin
      forever begin
         @(posedge clka);
         #1;
         chk("clka_out_hi_a", clka_out_a, 1);
         chk("clka_out_hi_b", clka_out_b, 1);
         @(negedge clka);
         #1;
         chk("clka_out_lo_a", clka_out_a, 0);
         chk("clka_out_lo_b", clka_out_b, 0);
         chk("out_a", out_a, out_model());
         chk("out_b", out_b, out_model());
         chk("clkb_a", clkb_a, clkb_model(edges, 1));
         chk("clkb_b", clkb_b, clkb_model(edges, 3));
      end
   end

   logic [7:0] sweep_tab [8];
   logic       pat1 [6];
   logic       pat3 [6];
   time        t_rise [2];
   int         n_rise;
   logic       prev_b;
   bit         found;

   initial begin
      sweep_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
      pat1      = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      pat3      = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

      rst_n = 1'b0;
      E     = 1'b0;
      In    = 3'd0;
      #5;
      chk("rst_clkb_a", clkb_a, 0);
      chk("rst_clkb_b", clkb_b, 0);
      chk("rst_out_a", out_a, 0);
      #20 rst_n = 1'b1;

      @(negedge clka);
      #1 chk("e0_in0", out_a, 8'h00);

      for (int i = 0; i < 8; i++) begin
         @(posedge clka);
         #2;
         E  = 1'b1;
         In = 3'(i);
         @(posedge clka);
         @(negedge clka);
         #1 chk("sweep", out_a, sweep_tab[i]);
      end

      @(posedge clka);
      #2 In = 3'd5;
      @(negedge clka);
      @(posedge clka);
      @(negedge clka);
      #1 chk("e1_in5", out_a, 8'h20);
      @(posedge clka);
      #2 E = 1'b0;
      @(posedge clka);
      @(negedge clka);
      #1 chk("e0_in5", out_a, 8'h00);

      @(posedge clka);
      #2 rst_n = 1'b0;
      #1;
      chk("pulse_clkb_a", clkb_a, 0);
      chk("pulse_clkb_b", clkb_b, 0);
      @(negedge clka);
      #2 rst_n = 1'b1;
      for (int j = 0; j < 6; j++) begin
         @(posedge clka);
         #1;
         chk("div1_seq", clkb_a, pat1[j]);
         chk("div3_seq", clkb_b, pat3[j]);
      end

      n_rise = 0;
      prev_b = clkb_a;
      for (int j = 0; j < 8; j++) begin
         @(posedge clka);
         #1;
         if (!prev_b && clkb_a && n_rise < 2) begin
            t_rise[n_rise] = $time;
            n_rise++;
         end
         prev_b = clkb_a;
      end
      chk("clkb_a_edges", n_rise, 2);
      if (n_rise == 2) chk("clkb_a_period", 32'(t_rise[1] - t_rise[0]), 40);

      found = 1'b0;
      for (int j = 0; j < 12 && !found; j++) begin
         @(posedge clka);
         #2;
         if (clkb_a === 1'b1 && clkb_b === 1'b1) found = 1'b1;
      end
      chk("find_high", found, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_clkb_a", clkb_a, 0);
      chk("mid_clkb_b", clkb_b, 0);
`ifdef DECODER_OUT_REG_EN
      chk("mid_out_a", out_a, 0);
`endif
      @(negedge clka);
      #2 rst_n = 1'b1;
      @(posedge clka);
      #1 chk("first_rise", clkb_a, 1);

      for (int j = 0; j < 400; j++) begin
         @(posedge clka);
         #2;
         E  = 1'($urandom);
         In = 3'($urandom);
         if ($urandom_range(0, 40) == 0) begin
            rst_n = 1'b0;
            @(negedge clka);
            #2 rst_n = 1'b1;
         end
      end

      @(posedge clka);
      #3;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
